// File: rtl/count_pkg.sv
// Shared types and constants for the count_reg counter block.
package count_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned MAX_WIDTH     = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Constant all-ones pattern of the given width, zero-extended to MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned width);
      logic [MAX_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/count_inc.sv
// Combinational incrementer: returns q+1 modulo 2^WIDTH and the carry-out.
module count_inc
   import count_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH-1:0] q_inc_o,
   output logic             carry_o
);

   assign {carry_o, q_inc_o} = {1'b0, q_i} + (WIDTH + 1)'(1);

endmodule

// File: rtl/count_reg.sv
// Loadable up-counter with IDLE/RUN/DONE control, sticky wrap flag and optional one-shot stop.
module count_reg
   import count_pkg::*;
#(
   parameter int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter bit          ONESHOT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cnt_en,
   input  logic             set_all,
   input  logic             ld_valid,
   input  logic [WIDTH-1:0] ld_data,
   output logic             ld_ready,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             busy
);

   localparam logic [WIDTH-1:0] AllOnes = WIDTH'(all_ones(WIDTH));

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] q_inc;
   logic             carry;
   logic             ld_acc;
   logic             inc_en;
   logic             wrap;

   count_inc #(
      .WIDTH (WIDTH)
   ) u_inc (
      .q_i     (q_q),
      .q_inc_o (q_inc),
      .carry_o (carry)
   );

   assign ld_ready = (state_q != RUN);
   assign ld_acc   = ld_valid & ld_ready;
   assign inc_en   = (state_q == RUN) & cnt_en;
   // A wrap only counts when the increment is the action actually applied.
   assign wrap     = inc_en & ~set_all & carry;

   always_comb begin
      q_d = q_q;
      if (set_all)     q_d = AllOnes;
      else if (ld_acc) q_d = ld_data;
      else if (inc_en) q_d = q_inc;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (wrap)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!ld_acc && start && !stop) state_d = RUN;
         end
         RUN: begin
            if (stop)                 state_d = IDLE;
            else if (wrap && ONESHOT) state_d = DONE;
         end
         DONE: begin
            if (ld_acc)              state_d = IDLE;
            else if (start && !stop) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q    = q_q;
   assign tc   = (q_q == AllOnes);
   assign ovf  = ovf_q;
   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_count_reg.sv
// Bench for count_reg: one free-running and one one-shot instance on shared stimulus.
module tb_count_reg;

   logic        clk = 1'b0;
   logic        rst_n, start, stop, cnt_en, set_all, ld_valid, clr_ovf;
   logic [15:0] ld_data;

   logic [15:0] q0, q1;
   logic        rdy0, tc0, ovf0, busy0;
   logic        rdy1, tc1, ovf1, busy1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   count_reg #(.WIDTH(16), .ONESHOT(1'b0)) dut0 (
      .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .cnt_en (cnt_en),
      .set_all (set_all), .ld_valid (ld_valid), .ld_data (ld_data), .ld_ready (rdy0),
      .clr_ovf (clr_ovf), .q (q0), .tc (tc0), .ovf (ovf0), .busy (busy0)
   );

   count_reg #(.WIDTH(16), .ONESHOT(1'b1)) dut1 (
      .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .cnt_en (cnt_en),
      .set_all (set_all), .ld_valid (ld_valid), .ld_data (ld_data), .ld_ready (rdy1),
      .clr_ovf (clr_ovf), .q (q1), .tc (tc1), .ovf (ovf1), .busy (busy1)
   );

   // Control bits {rst_n, start, stop, cnt_en, set_all, ld_valid, clr_ovf}; absent R = reset.
   localparam logic [6:0] R = 7'b1000000, S = 7'b0100000, P = 7'b0010000, E = 7'b0001000;
   localparam logic [6:0] A = 7'b0000100, L = 7'b0000010, C = 7'b0000001;
   // Flag bits {ovf, busy, ld_ready, tc}.
   localparam logic [3:0] O = 4'b1000, B = 4'b0100, Y = 4'b0010, T = 4'b0001;

   typedef struct {
      string       tag;
      logic [15:0] q0;
      logic [3:0]  f0;
      logic        chk1;
      logic [15:0] q1;
      logic [3:0]  f1;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc(input string tag, input logic [6:0] ctl, input logic [15:0] d,
                      input logic [15:0] eq0, input logic [3:0] ef0, input logic c1,
                      input logic [15:0] eq1, input logic [3:0] ef1);
      exp_t e;
      @(negedge clk);
      {rst_n, start, stop, cnt_en, set_all, ld_valid, clr_ovf} = ctl;
      ld_data = d;
      e.tag = tag; e.q0 = eq0; e.f0 = ef0; e.chk1 = c1; e.q1 = eq1; e.f1 = ef1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, "_q0"}, 32'(q0), 32'(e.q0));
      check({e.tag, "_flags0"}, 32'({ovf0, busy0, rdy0, tc0}), 32'(e.f0));
      if (e.chk1) begin
         check({e.tag, "_q1"}, 32'(q1), 32'(e.q1));
         check({e.tag, "_flags1"}, 32'({ovf1, busy1, rdy1, tc1}), 32'(e.f1));
      end
   endtask

   // Both instances expected to agree.
   task automatic step(input string tag, input logic [6:0] ctl, input logic [15:0] d,
                       input logic [15:0] eq, input logic [3:0] ef);
      cyc(tag, ctl, d, eq, ef, 1'b1, eq, ef);
   endtask

   task automatic stepd(input string tag, input logic [6:0] ctl, input logic [15:0] d,
                        input logic [15:0] eq0, input logic [3:0] ef0,
                        input logic [15:0] eq1, input logic [3:0] ef1);
      cyc(tag, ctl, d, eq0, ef0, 1'b1, eq1, ef1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      {rst_n, start, stop, cnt_en, set_all, ld_valid, clr_ovf} = 7'b0;
      ld_data = 16'h0;

      // Reset, load, run three increments, load ignored in RUN.
      step("rst",        7'b0,      16'h0,    16'h0000, Y);
      step("ld1234",     R|L,       16'h1234, 16'h1234, Y);
      step("start",      R|S|E,     16'h0,    16'h1234, B);
      step("inc1",       R|E,       16'h0,    16'h1235, B);
      step("inc2",       R|E,       16'h0,    16'h1236, B);
      step("inc3",       R|E,       16'h0,    16'h1237, B);
      step("run_ld",     R|E|L,     16'h5555, 16'h1238, B);
      step("run_noen",   R,         16'h0,    16'h1238, B);
      step("run_set",    R|A|E,     16'h0,    16'hFFFF, B|T);
      stepd("wrap_set",  R|E,       16'h0,    16'h0000, O|B, 16'h0000, O|Y);

      // Wrap from FFFE; one-shot parks in DONE.
      step("rst2",       7'b0,      16'h0,    16'h0000, Y);
      step("ld_fffe",    R|L,       16'hFFFE, 16'hFFFE, Y);
      step("start2",     R|S|E,     16'h0,    16'hFFFE, B);
      step("inc_ffff",   R|E,       16'h0,    16'hFFFF, B|T);
      stepd("wrap",      R|E,       16'h0,    16'h0000, O|B, 16'h0000, O|Y);
      step("stop_ss",    R|S|P,     16'h0,    16'h0000, O|Y);
      step("done_ld",    R|L,       16'h00AA, 16'h00AA, O|Y);
      step("restart",    R|S,       16'h0,    16'h00AA, O|B);
      step("clr",        R|C,       16'h0,    16'h00AA, B);

      // clr_ovf loses to a simultaneous wrap.
      step("rst3",       7'b0,      16'h0,    16'h0000, Y);
      step("ld_ffff",    R|L,       16'hFFFF, 16'hFFFF, Y|T);
      step("start3",     R|S,       16'h0,    16'hFFFF, B|T);
      stepd("wrap3",     R|E,       16'h0,    16'h0000, O|B, 16'h0000, O|Y);
      stepd("set_ovf",   R|A,       16'h0,    16'hFFFF, O|B|T, 16'hFFFF, O|Y|T);
      stepd("clr_wrap",  R|E|C,     16'h0,    16'h0000, O|B, 16'hFFFF, Y|T);
      stepd("clr_only",  R|C,       16'h0,    16'h0000, B, 16'hFFFF, Y|T);

      // Stop in the wrap cycle still increments and flags.
      stepd("set4",      R|A,       16'h0,    16'hFFFF, B|T, 16'hFFFF, Y|T);
      stepd("stop_wrap", R|E|P,     16'h0,    16'h0000, O|Y, 16'hFFFF, Y|T);

      // IDLE corner cases.
      step("rst4",       7'b0,      16'h0,    16'h0000, Y);
      step("ss_idle",    R|S|P,     16'h0,    16'h0000, Y);
      step("set_ld",     R|A|L,     16'h00AA, 16'hFFFF, Y|T);
      step("idle_hold",  R|E,       16'h0,    16'hFFFF, Y|T);

      // Reset mid-count at 0x0042 with ovf set.
      step("start5",     R|S,       16'h0,    16'hFFFF, B|T);
      stepd("wrap5",     R|E,       16'h0,    16'h0000, O|B, 16'h0000, O|Y);
      step("stop5",      R|P,       16'h0,    16'h0000, O|Y);
      step("ld0041",     R|L,       16'h0041, 16'h0041, O|Y);
      step("start6",     R|S,       16'h0,    16'h0041, O|B);
      step("inc42",      R|E,       16'h0,    16'h0042, O|B);
      step("rst_mid",    E|C,       16'h0,    16'h0000, Y);
      step("post_rst",   R|E,       16'h0,    16'h0000, Y);

      // Reset wins in the wrap cycle.
      step("ld_ffff2",   R|L,       16'hFFFF, 16'hFFFF, Y|T);
      step("start7",     R|S,       16'h0,    16'hFFFF, B|T);
      step("rst_wrap",   E|S,       16'h0,    16'h0000, Y);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
